// File: rtl/fp16_operand_unpacker_pkg.sv
// Shared FP16 operand-path definitions: unpacker state encoding and
// half-precision field layout, also used by the FP16-to-FP32 converter.
package fp16_operand_unpacker_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FIRST,
        SECOND,
        FULL
    } unpack_state_e;

    localparam int FP16_MAN_LO   = 0;
    localparam int FP16_MAN_HI   = 9;
    localparam int FP16_EXP_LO   = FP16_MAN_HI + 1;
    localparam int FP16_EXP_HI   = 14;
    localparam int FP16_SIGN_BIT = FP16_EXP_HI + 1;
    localparam int FP16_W        = FP16_SIGN_BIT + 1;

    localparam int LANE_W = FP16_W;

endpackage

// File: rtl/fp16_operand_unpacker_if.sv
// Operand-buffer side and converter side of the FP16 operand unpacker.
interface fp16_operand_unpacker_if #(
    parameter int PARM_XLEN = 32
);

    logic                 in_valid;
    logic                 in_ready;
    logic [PARM_XLEN-1:0] in_data;
    logic                 in_is_fp16;
    logic                 in_last;

    logic                 out_valid;
    logic                 out_ready;
    logic [PARM_XLEN-1:0] out_data;
    logic                 out_mode;
    logic                 out_lane;
    logic                 out_last;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_is_fp16,
        output in_last,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_mode,
        input  out_lane,
        input  out_last
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_is_fp16,
        input  in_last,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_mode,
        output out_lane,
        output out_last
    );

endinterface

// File: rtl/fp16_operand_unpacker.sv
// Splits packed FP16 operand words into two zero-extended converter beats;
// FP32 words pass through as a single beat with the convert bit cleared.
module fp16_operand_unpacker
    import fp16_operand_unpacker_pkg::*;
#(
    parameter int PARM_XLEN = 32,
    parameter bit HI_FIRST  = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    fp16_operand_unpacker_if.slave          bus
);

    if (PARM_XLEN != 32) begin : g_xlen_check
        $error("fp16_operand_unpacker: PARM_XLEN must be 32");
    end

    unpack_state_e        state_q, state_d;
    logic [PARM_XLEN-1:0] word_q;
    logic                 is16_q;
    logic                 last_q;

    logic                 hs;
    logic                 lane;
    logic [LANE_W-1:0]    half;

    assign bus.in_ready = (state_q == EMPTY) ||
                          (bus.out_ready &&
                           (state_q == SECOND || state_q == FULL));

    assign hs = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            word_q  <= '0;
            is16_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                word_q <= bus.in_data;
                is16_q <= bus.in_is_fp16;
                last_q <= bus.in_last;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (hs) state_d = bus.in_is_fp16 ? FIRST : FULL;
            end
            FIRST: begin
                if (bus.out_ready) state_d = SECOND;
            end
            SECOND, FULL: begin
                if (bus.out_ready) begin
                    if (hs) state_d = bus.in_is_fp16 ? FIRST : FULL;
                    else    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Lane order within a word is fixed at elaboration by HI_FIRST.
    always_comb begin
        lane = 1'b0;
        unique case (state_q)
            FIRST:   lane = HI_FIRST;
            SECOND:  lane = !HI_FIRST;
            default: lane = 1'b0;
        endcase
    end

    assign half = lane ? word_q[2*LANE_W-1:LANE_W]
                       : word_q[LANE_W-1:0];

    always_comb begin
        bus.out_valid = (state_q != EMPTY);
        bus.out_data  = '0;
        bus.out_lane  = 1'b0;
        bus.out_last  = 1'b0;
        unique case (state_q)
            FIRST: begin
                bus.out_data = {{(PARM_XLEN-LANE_W){1'b0}}, half};
                bus.out_lane = lane;
            end
            SECOND: begin
                bus.out_data = {{(PARM_XLEN-LANE_W){1'b0}}, half};
                bus.out_lane = lane;
                bus.out_last = last_q;
            end
            FULL: begin
                bus.out_data = word_q;
                bus.out_last = last_q;
            end
            default: ;
        endcase
        bus.out_mode = is16_q && bus.out_valid;
    end

endmodule

// File: tb/tb_fp16_operand_unpacker.sv
// Bench for fp16_operand_unpacker: directed scenarios plus a randomized
// stream scored against a beat-queue reference model.
module tb_fp16_operand_unpacker;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp16_operand_unpacker_if #(.PARM_XLEN(32)) a_if ();
    fp16_operand_unpacker_if #(.PARM_XLEN(32)) b_if ();

    fp16_operand_unpacker #(
        .PARM_XLEN(32),
        .HI_FIRST (1'b0)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(a_if.slave)
    );

    fp16_operand_unpacker #(
        .PARM_XLEN(32),
        .HI_FIRST (1'b1)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(b_if.slave)
    );

    typedef struct {
        logic [31:0] d;
        logic        m;
        logic        l;
        logic        la;
    } beat_t;

    function automatic logic [35:0] obs_a();
        return {a_if.out_valid, a_if.out_data, a_if.out_mode,
                a_if.out_lane, a_if.out_last};
    endfunction

    function automatic logic [35:0] obs_b();
        return {b_if.out_valid, b_if.out_data, b_if.out_mode,
                b_if.out_lane, b_if.out_last};
    endfunction

    function automatic logic [35:0] bt(logic v, logic [31:0] d,
                                       logic m, logic l, logic la);
        return {v, d, m, l, la};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_a(logic v, logic [31:0] d, logic f16, logic last);
        a_if.in_valid   = v;
        a_if.in_data    = d;
        a_if.in_is_fp16 = f16;
        a_if.in_last    = last;
    endtask

    task automatic test_reset();
        logic [35:0] got;
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        got = obs_a();
        n_run++;
        if (got !== bt(0, 32'h0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want %h", got,
                     bt(0, 32'h0, 0, 0, 0));
        end
        n_run++;
        if (a_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b want 1", a_if.in_ready);
        end
    endtask

    task automatic test_single_fp16();
        logic [35:0] exp_b [3];
        logic [35:0] got;
        exp_b[0] = bt(1, 32'h0000C000, 1, 0, 0);
        exp_b[1] = bt(1, 32'h00003C00, 1, 1, 1);
        exp_b[2] = bt(0, 32'h0, 0, 0, 0);
        @(negedge clk);
        a_if.out_ready = 1'b1;
        drive_a(1, 32'h3C00C000, 1, 1);
        #1;
        n_run++;
        if (a_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fp16_accept got %b want 1", a_if.in_ready);
        end
        step();
        drive_a(0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            got = obs_a();
            n_run++;
            if (got !== exp_b[i]) begin
                n_fail++;
                $display("FAIL fp16_beat%0d got %h want %h", i, got, exp_b[i]);
            end
            step();
        end
    endtask

    task automatic test_stream_fp32();
        logic [31:0] w [3];
        logic [35:0] got;
        w[0] = 32'h3F800000;
        w[1] = 32'h40000000;
        w[2] = 32'hC0400000;
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive_a(1, w[i], 0, (i == 2));
            else       drive_a(0, 32'h0, 0, 0);
            #1;
            if (i < 3) begin
                n_run++;
                if (a_if.in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fp32_ready%0d got %b want 1", i,
                             a_if.in_ready);
                end
            end
            if (i > 0) begin
                got = obs_a();
                n_run++;
                if (i < 4 && got !== bt(1, w[i-1], 0, 0, (i == 3))) begin
                    n_fail++;
                    $display("FAIL fp32_beat%0d got %h want %h", i - 1, got,
                             bt(1, w[i-1], 0, 0, (i == 3)));
                end else if (i == 4 && got !== bt(0, 32'h0, 0, 0, 0)) begin
                    n_fail++;
                    $display("FAIL fp32_idle got %h want %h", got,
                             bt(0, 32'h0, 0, 0, 0));
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] got;
        logic [35:0] want;
        a_if.out_ready = 1'b1;
        drive_a(1, 32'h7C000001, 1, 0);
        step();
        drive_a(0, 32'h0, 0, 0);
        #1;
        got = obs_a();
        n_run++;
        if (got !== bt(1, 32'h00000001, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL bp_first got %h want %h", got,
                     bt(1, 32'h00000001, 1, 0, 0));
        end
        step();
        a_if.out_ready = 1'b0;
        want = bt(1, 32'h00007C00, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            got = obs_a();
            n_run++;
            if (got !== want || a_if.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d got %h rdy %b want %h rdy 0", i,
                         got, a_if.in_ready, want);
            end
            step();
        end
        a_if.out_ready = 1'b1;
        drive_a(1, 32'h11223344, 0, 1);
        #1;
        got = obs_a();
        n_run++;
        if (got !== want || a_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release got %h rdy %b want %h rdy 1", got,
                     a_if.in_ready, want);
        end
        step();
        drive_a(0, 32'h0, 0, 0);
        #1;
        got = obs_a();
        n_run++;
        if (got !== bt(1, 32'h11223344, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL bp_next got %h want %h", got,
                     bt(1, 32'h11223344, 0, 0, 1));
        end
        step();
    endtask

    task automatic test_mixed();
        logic [35:0] got;
        logic [35:0] exp_b [3];
        logic        exp_r [3];
        exp_b[0] = bt(1, 32'h00000400, 1, 0, 0);
        exp_b[1] = bt(1, 32'h00000001, 1, 1, 0);
        exp_b[2] = bt(1, 32'h7FC00000, 0, 0, 1);
        exp_r[0] = 1'b0;
        exp_r[1] = 1'b1;
        exp_r[2] = 1'b1;
        a_if.out_ready = 1'b1;
        drive_a(1, 32'h00010400, 1, 0);
        step();
        drive_a(1, 32'h7FC00000, 0, 1);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) drive_a(0, 32'h0, 0, 0);
            #1;
            got = obs_a();
            n_run++;
            if (got !== exp_b[i] || a_if.in_ready !== exp_r[i]) begin
                n_fail++;
                $display("FAIL mixed_beat%0d got %h rdy %b want %h rdy %b",
                         i, got, a_if.in_ready, exp_b[i], exp_r[i]);
            end
            step();
        end
    endtask

    task automatic test_hi_first();
        logic [35:0] got;
        logic [35:0] exp_b [2];
        exp_b[0] = bt(1, 32'h0000ABCD, 1, 1, 0);
        exp_b[1] = bt(1, 32'h00001234, 1, 0, 1);
        b_if.out_ready  = 1'b1;
        b_if.in_valid   = 1'b1;
        b_if.in_data    = 32'hABCD1234;
        b_if.in_is_fp16 = 1'b1;
        b_if.in_last    = 1'b1;
        step();
        b_if.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            got = obs_b();
            n_run++;
            if (got !== exp_b[i]) begin
                n_fail++;
                $display("FAIL hi_first_beat%0d got %h want %h", i, got,
                         exp_b[i]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [35:0] got;
        a_if.out_ready = 1'b1;
        drive_a(1, 32'hBEEF5555, 1, 1);
        step();
        drive_a(0, 32'h0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            got = obs_a();
            n_run++;
            if (got !== bt(0, 32'h0, 0, 0, 0) || a_if.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_mid%0d got %h rdy %b want %h rdy 1", i,
                         got, a_if.in_ready, bt(0, 32'h0, 0, 0, 0));
            end
            step();
        end
    endtask

    task automatic test_random();
        beat_t       q [$];
        beat_t       e;
        logic        pend;
        logic [31:0] w;
        logic        f16, lst, exp_rdy;
        logic [35:0] got;
        int          errs;
        errs = 0;
        pend = 1'b0;
        w = '0;
        f16 = 1'b0;
        lst = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!pend && ($urandom_range(3) != 0)) begin
                pend = 1'b1;
                w = $urandom;
                f16 = $urandom_range(1);
                lst = $urandom_range(1);
            end
            drive_a(pend, w, f16, lst);
            a_if.out_ready = ($urandom_range(3) != 0);
            #1;
            exp_rdy = (q.size() == 0) ||
                      (q.size() == 1 && a_if.out_ready);
            got = obs_a();
            n_run++;
            if (q.size() == 0) begin
                if (got !== bt(0, 32'h0, 0, 0, 0) ||
                    a_if.in_ready !== exp_rdy) begin
                    n_fail++;
                    errs++;
                    if (errs < 5)
                        $display("FAIL rand_idle c%0d got %h rdy %b want %h",
                                 cyc, got, a_if.in_ready,
                                 bt(0, 32'h0, 0, 0, 0));
                end
            end else begin
                e = q[0];
                if (got !== bt(1, e.d, e.m, e.l, e.la) ||
                    a_if.in_ready !== exp_rdy) begin
                    n_fail++;
                    errs++;
                    if (errs < 5)
                        $display("FAIL rand_beat c%0d got %h rdy %b want %h rdy %b",
                                 cyc, got, a_if.in_ready,
                                 bt(1, e.d, e.m, e.l, e.la), exp_rdy);
                end
                if (a_if.out_ready) void'(q.pop_front());
            end
            if (pend && exp_rdy) begin
                if (f16) begin
                    q.push_back('{{16'h0, w[15:0]}, 1'b1, 1'b0, 1'b0});
                    q.push_back('{{16'h0, w[31:16]}, 1'b1, 1'b1, lst});
                end else begin
                    q.push_back('{w, 1'b0, 1'b0, lst});
                end
                pend = 1'b0;
            end
            step();
        end
        drive_a(0, 32'h0, 0, 0);
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        drive_a(0, 32'h0, 0, 0);
        a_if.out_ready  = 1'b1;
        b_if.in_valid   = 1'b0;
        b_if.in_data    = 32'h0;
        b_if.in_is_fp16 = 1'b0;
        b_if.in_last    = 1'b0;
        b_if.out_ready  = 1'b1;
        test_reset();
        test_single_fp16();
        test_stream_fp32();
        test_backpressure();
        test_mixed();
        test_hi_first();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
